// File: rtl/pipe_skid_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg_pkg
//  Description : Shared pipeline types and widths for the skid-buffered
//                pipeline register (state encoding, IF/ID payload widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_skid_reg_pkg;

    localparam int INST_W    = 32;
    localparam int PC_W      = 32;
    localparam int PAYLOAD_W = INST_W + PC_W;

    // Encoding doubles as the entry count, so occupancy falls out of the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] occ_of(input state_t st);
        case (st)
            HALF:    occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage : pipe_skid_reg_pkg
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Two-entry skid pipeline register with registered in_ready,
//                synchronous flush and a saturating output-stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                DATA_W    = PAYLOAD_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_main;
    logic [DATA_W-1:0]  r_skid;
    logic [DATA_W-1:0]  w_main_nxt;
    logic [DATA_W-1:0]  w_skid_nxt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_stall;
    logic               w_stall_max;

    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_stall_max = &r_stall_cnt;
    assign w_stall     = out_valid & ~out_ready & ~flush;

    // ------------------------------------------------------------------
    // State and storage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= FLUSH_VAL;
            r_skid  <= FLUSH_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and storage update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = FLUSH_VAL;
            w_skid_nxt  = FLUSH_VAL;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = HALF;
                    end
                end
                HALF: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt  = in_data;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = in_data;
                        w_state_nxt = FULL;
                    end else if (w_out_fire) begin
                        w_main_nxt  = FLUSH_VAL;
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = FLUSH_VAL;
                        w_state_nxt = HALF;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = FLUSH_VAL;
                    w_skid_nxt  = FLUSH_VAL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake outputs, decoded from the state flops only
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = occ_of(r_state);
        case (r_state)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            HALF: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_data = r_main;

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !w_stall_max) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule : pipe_skid_reg
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_reg
//  Description : Self-checking bench for pipe_skid_reg against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          s_flush;
    logic          s_in_valid;
    logic          s_in_ready;
    logic [DW-1:0] s_in_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occupancy;
    logic [3:0]    s_stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    int unsigned   m_stall;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL('0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.DATA_W(DW), .FLUSH_VAL('0), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("occupancy", DW'(occupancy), DW'(mq.size()));
        chk("out_valid", DW'(out_valid), DW'(mq.size() > 0));
        chk("in_ready",  DW'(in_ready),  DW'(mq.size() < 2));
        chk("out_data",  out_data, (mq.size() > 0) ? mq[0] : '0);
        chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
    endtask

    // One clock of traffic, entered and left at a falling edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
        logic m_ir, m_ov;
        m_ir = (mq.size() < 2);
        m_ov = (mq.size() > 0);
        in_valid  = iv;
        in_data   = id;
        flush     = fl;
        out_ready = ~ordy;
        #1;
        chk("in_ready_vs_out_ready_lo", DW'(in_ready), DW'(m_ir));
        out_ready = ordy;
        #1;
        chk("in_ready_vs_out_ready_hi", DW'(in_ready), DW'(m_ir));
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (m_ov && ordy) void'(mq.pop_front());
            if (iv && m_ir) mq.push_back(id);
        end
        if (m_ov && !ordy && !fl && m_stall < 32'hFFFF) m_stall++;
        @(negedge clk);
        chk_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        #1;
        chk("rst_async_occ",   DW'(occupancy), '0);
        chk("rst_async_valid", DW'(out_valid), '0);
        chk("rst_async_ready", DW'(in_ready),  1);
        chk("rst_async_data",  out_data, '0);
        chk("rst_async_stall", DW'(stall_cnt), '0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_valid", DW'(out_valid), '0);
        chk("rst_hold_ready", DW'(in_ready),  1);
        chk("rst_hold_data",  out_data, '0);
        chk("rst_hold_stall", DW'(stall_cnt), '0);
        rst = 1'b0;
        in_valid = 1'b0;
        mq.delete();
        m_stall = 0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        m_stall = 0;
        @(negedge clk);
        do_reset();

        // streaming: each word visible one edge after it is accepted
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, DW'(k), 1'b1, 1'b0);
            chk("stream_data", out_data, DW'(k));
            chk("stream_occ",  DW'(occupancy), 1);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("stream_drained", DW'(out_valid), 0);

        // backpressure: A, B stored, C held upstream
        do_reset();
        cycle(1'b1, 64'hA, 1'b0, 1'b0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 1'b0, 1'b0);
        chk("bp_occ_full", DW'(occupancy), 2);
        chk("bp_not_ready", DW'(in_ready), 0);
        chk("bp_head_a", out_data, 64'hA);
        cycle(1'b1, 64'hC, 1'b1, 1'b0);
        chk("bp_head_b", out_data, 64'hB);
        cycle(1'b1, 64'hC, 1'b1, 1'b0);
        chk("bp_head_c", out_data, 64'hC);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("bp_empty", DW'(occupancy), 0);
        chk("bp_stall", DW'(stall_cnt), 2);

        // flush while FULL beats same-cycle input and output
        do_reset();
        cycle(1'b1, 64'h11, 1'b0, 1'b0);
        cycle(1'b1, 64'h22, 1'b0, 1'b0);
        cycle(1'b1, 64'h55, 1'b1, 1'b1);
        chk("flush_occ",   DW'(occupancy), 0);
        chk("flush_data",  out_data, '0);
        chk("flush_stall", DW'(stall_cnt), 1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("flush_no_out", DW'(out_valid), 0);

        // async reset in the middle of a transfer
        cycle(1'b1, 64'h77, 1'b0, 1'b0);
        cycle(1'b1, 64'h88, 1'b0, 1'b0);
        do_reset();

        // saturation on the 4-bit counter instance
        s_in_valid = 1'b1; s_in_data = 64'h7; s_out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("sat_occ", DW'(s_occupancy), 1);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 15) chk("sat_at_15", DW'(s_stall_cnt), 15);
        end
        chk("sat_after_20", DW'(s_stall_cnt), 15);
        chk("sat_data_held", s_out_data, 64'h7);

        // randomized traffic against the queue model
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            cycle(($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
                  {$urandom, $urandom},
                  ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_skid_reg
`default_nettype wire
